// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register.
//   The register file and decoder feed this stage. Each cycle it captures the
//   operands, immediate, register addresses and control bits for EX.
//   It detects load-use hazards: it inserts one bubble and stalls IF/ID for
//   that cycle. It also honours branch flush and EX-side hold, and it counts
//   the load-use bubbles it has inserted.
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   valid_i .. MemtoReg_i   decoded instruction from ID
//   flush_i                 kill the instruction in ID (branch taken)
//   hold_i                  EX/MEM cannot accept; freeze this stage
//   valid_o .. MemtoReg_o   registered copies for EX
//   stall_o                 combinational; freeze PC and IF/ID this cycle
//   bubble_cnt_o            saturating count of load-use bubbles since reset
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  RSdata_i,
    input  logic [DATA_W-1:0]  RTdata_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [ADDR_W-1:0]  RSaddr_i,
    input  logic [ADDR_W-1:0]  RTaddr_i,
    input  logic [ADDR_W-1:0]  RDaddr_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic               ALUSrc_i,
    input  logic               RegWrite_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic               MemtoReg_i,
    input  logic               flush_i,
    input  logic               hold_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  RSdata_o,
    output logic [DATA_W-1:0]  RTdata_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [ADDR_W-1:0]  RSaddr_o,
    output logic [ADDR_W-1:0]  RTaddr_o,
    output logic [ADDR_W-1:0]  RDaddr_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               ALUSrc_o,
    output logic               RegWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               MemtoReg_o,
    output logic               stall_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    // One bundle for the whole stage. A bubble is this bundle all zero.
    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic [ADDR_W-1:0]  rs_addr;
        logic [ADDR_W-1:0]  rt_addr;
        logic [ADDR_W-1:0]  rd_addr;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
    } id_ex_t;

    id_ex_t d, q;
    logic   lu;

    assign d = '{valid: valid_i, rs_data: RSdata_i, rt_data: RTdata_i, imm: imm_i,
                 rs_addr: RSaddr_i, rt_addr: RTaddr_i, rd_addr: RDaddr_i,
                 alu_op: ALUOp_i, alu_src: ALUSrc_i, reg_write: RegWrite_i,
                 mem_read: MemRead_i, mem_write: MemWrite_i, mem_to_reg: MemtoReg_i};

    // A load in EX whose destination is read by the instruction in ID.
    // r0 is hardwired, so it never creates a dependency.
    assign lu = q.valid & q.mem_read & (q.rd_addr != '0) & valid_i &
                ((RSaddr_i == q.rd_addr) | (RTaddr_i == q.rd_addr));

    // A flushed instruction is dead, so it cannot cause a stall.
    assign stall_o = hold_i | (lu & ~flush_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (hold_i) begin
            q <= q;
        end else if (flush_i || lu) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    // The counter counts only bubbles caused by a load-use hazard.
    // It saturates instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_o <= '0;
        end else if (!hold_i && !flush_i && lu && (bubble_cnt_o != {CNT_W{1'b1}})) begin
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

    assign valid_o    = q.valid;
    assign RSdata_o   = q.rs_data;
    assign RTdata_o   = q.rt_data;
    assign imm_o      = q.imm;
    assign RSaddr_o   = q.rs_addr;
    assign RTaddr_o   = q.rt_addr;
    assign RDaddr_o   = q.rd_addr;
    assign ALUOp_o    = q.alu_op;
    assign ALUSrc_o   = q.alu_src;
    assign RegWrite_o = q.reg_write;
    assign MemRead_o  = q.mem_read;
    assign MemWrite_o = q.mem_write;
    assign MemtoReg_o = q.mem_to_reg;

endmodule
